axis_video_pattern_gen: RTL and testbench
=========================================

// Module: axis_video_pattern_gen
// PURPOSE
//  AXI4-Stream video frame source: emits FRAME_WIDTH x FRAME_HEIGHT frames of
//  synthetic pixels with SOF (tuser) and EOL (tlast) markers, honouring tready.
//  Drives the s_axis input of the stream filters for bring-up and self-test.
// PARAMETERS
//  DATA_WIDTH    8    pixel width (bits), >= 4
//  FRAME_WIDTH   640  pixels per line, >= 2
//  FRAME_HEIGHT  512  lines per frame, >= 2
//  HGAP_CYCLES   0    idle cycles after each line except the last line of a frame
//  VGAP_CYCLES   16   idle cycles after the last line of each frame
// PORTS
//  clk            in   1            clock; all logic on rising edge
//  rst_n          in   1            asynchronous active-low reset
//  enable         in   1            1 = stream frames; 0 = stop at frame boundary
//  pattern_sel    in   2            0 h-ramp, 1 v-ramp, 2 checker, 3 LFSR
//  m_axis_tdata   out  DATA_WIDTH   pixel
//  m_axis_tvalid  out  1            pixel valid
//  m_axis_tlast   out  1            last pixel of line
//  m_axis_tuser   out  1            first pixel of frame
//  m_axis_tready  in   1            downstream ready
//  frame_done     out  1            1-cycle pulse on fire of the last pixel of a frame
//  frame_cnt      out  16           completed frames, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (asynchronous, rst_n low): all outputs 0; state IDLE; hcnt=vcnt=0;
//    frame_cnt=0; LFSR=16'hACE1. Reset mid-frame discards the frame with no tlast.
//  - fire = tvalid & tready. All outputs are registered.
//  - FSM IDLE -> ACTIVE when enable=1: latch pattern_sel, hcnt=vcnt=0, reseed LFSR.
//    tvalid rises the cycle after enable is sampled high (1-cycle start latency).
//  - ACTIVE: tvalid=1. On fire, hcnt++. On the fire with hcnt=FRAME_WIDTH-1:
//    hcnt=0 and vcnt++. If vcnt<FRAME_HEIGHT-1, go to HGAP (skipped when
//    HGAP_CYCLES=0, stay ACTIVE). If vcnt=FRAME_HEIGHT-1, go to VGAP.
//  - HGAP: tvalid=0 for exactly HGAP_CYCLES cycles, then ACTIVE.
//  - VGAP: tvalid=0 for exactly VGAP_CYCLES cycles (minimum 1 cycle when
//    VGAP_CYCLES=0). Then: enable=1 -> new frame (relatch pattern_sel, reseed);
//    enable=0 -> IDLE.
//  - enable is only sampled in IDLE and at the end of VGAP; frames are never cut.
//  - AXIS hold: while tvalid=1 & tready=0, tdata/tlast/tuser are stable.
//    tvalid is never dropped before fire.
//  - tuser=1 only when hcnt=0 & vcnt=0; tlast=1 only when hcnt=FRAME_WIDTH-1.
//  - Pixel value for the current (hcnt,vcnt), truncated to DATA_WIDTH LSBs:
//    0: hcnt;  1: vcnt;  2: (hcnt[3]^vcnt[3]) ? all-ones : 0;
//    3: LFSR[DATA_WIDTH-1:0]. The LFSR is a Fibonacci x^16+x^14+x^13+x^11+1
//       register, shifted left with feedback into bit 0, stepped once per fire only.
//  - pattern_sel changes mid-frame have no effect until the next frame start.
//  - On the fire of the final pixel: frame_done=1 next cycle for 1 cycle;
//    frame_cnt+1 in the same cycle.
//  - Throughput with tready=1 and zero gaps: 1 pixel/clk.
// TESTING
//  T1 W=4,H=2,VGAP=2, sel=0, tready=1, enable=1 -> data 0,1,2,3,0,1,2,3;
//     tuser on beat0; tlast on beats 3,7; frame_done 1 cycle later; 2 idle
//     cycles; next frame starts with tuser.
//  T2 T1 config, tready toggled randomly -> each beat fires exactly once;
//     payload is stable while stalled; sequence is identical to T1.
//  T3 sel=2, W=H=16 -> pixel(8,0)=0xFF, pixel(8,8)=0x00, pixel(0,8)=0xFF.
//  T4 sel=3 -> first beat 0xE1; two frames give identical sequences (reseed);
//     stalls do not advance the LFSR.
//  T5 enable dropped mid-frame -> current frame completes fully, then IDLE
//     with tvalid=0; frame_cnt=1.
//  T6 rst_n pulsed low mid-line -> outputs 0 immediately; after release with
//     enable=1, the next frame starts at (0,0) with tuser=1; frame_cnt=0.

Source files
------------

// File: rtl/axis_video_pattern_gen.sv
// rtl/axis_video_pattern_gen.sv - AXI4-Stream synthetic video frame source
//
// Emits FRAME_WIDTH x FRAME_HEIGHT frames of generated pixels. The stream marks
// the first pixel of each frame with tuser and the last pixel of each line with
// tlast. It honours tready and can insert idle gaps between lines and frames.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         1 = stream frames, 0 = stop at the next frame boundary
//   pattern_sel    0 h-ramp, 1 v-ramp, 2 8x8 checker, 3 LFSR (latched per frame)
//   m_axis_tdata   pixel value
//   m_axis_tvalid  pixel valid
//   m_axis_tlast   last pixel of a line
//   m_axis_tuser   first pixel of a frame
//   m_axis_tready  downstream ready
//   frame_done     one-cycle pulse after the last pixel of a frame is accepted
//   frame_cnt      completed frames, wraps at 16 bits

module axis_video_pattern_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int HGAP_CYCLES  = 0,
    parameter int VGAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int HW       = $clog2(FRAME_WIDTH);
    localparam int VW       = $clog2(FRAME_HEIGHT);
    // A frame gap of zero still costs one cycle so enable can be sampled.
    localparam int VGAP_EFF = (VGAP_CYCLES > 0) ? VGAP_CYCLES : 1;
    localparam int GAP_MAX  = (HGAP_CYCLES > VGAP_EFF) ? HGAP_CYCLES : VGAP_EFF;
    localparam int GW       = $clog2(GAP_MAX + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(FRAME_WIDTH - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(FRAME_HEIGHT - 1);
    localparam logic [GW-1:0] HG_LAST   = GW'((HGAP_CYCLES > 0) ? HGAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] VG_LAST   = GW'(VGAP_EFF - 1);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HGAP   = 2'd2,
        S_VGAP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [HW-1:0]         r_hcnt;
    logic [VW-1:0]         r_vcnt;
    logic [15:0]           r_lfsr;
    logic [1:0]            r_sel;
    logic [GW-1:0]         r_gap;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_tuser;
    logic                  r_frame_done;
    logic [15:0]           r_frame_cnt;

    state_t                w_state_nxt;
    logic                  w_start;
    logic                  w_fire;
    logic                  w_eol;
    logic                  w_eof;
    logic                  w_lfsr_fb;
    logic [HW-1:0]         w_hcnt_nxt;
    logic [VW-1:0]         w_vcnt_nxt;
    logic [15:0]           w_lfsr_nxt;
    logic [1:0]            w_sel_nxt;
    logic [DATA_WIDTH-1:0] w_h_px;
    logic [DATA_WIDTH-1:0] w_v_px;
    logic [DATA_WIDTH-1:0] w_l_px;
    logic                  w_h3;
    logic                  w_v3;
    logic [DATA_WIDTH-1:0] w_pixel;
    logic [DATA_WIDTH-1:0] w_tdata_nxt;
    logic                  w_tvalid_nxt;
    logic                  w_tlast_nxt;
    logic                  w_tuser_nxt;

    // tvalid is only ever high in ACTIVE, so this is the handshake.
    assign w_fire    = r_tvalid & m_axis_tready;
    assign w_eol     = w_fire && (r_hcnt == H_LAST);
    assign w_eof     = w_eol && (r_vcnt == V_LAST);
    // x^16 + x^14 + x^13 + x^11 + 1, shifted left, feedback into bit 0.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; w_start marks the cycles where a new frame is launched.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_eof) begin
                    w_state_nxt = S_VGAP;
                end else if (w_eol && (HGAP_CYCLES > 0)) begin
                    w_state_nxt = S_HGAP;
                end
            end
            S_HGAP: begin
                if (r_gap == HG_LAST) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_VGAP: begin
                if (r_gap == VG_LAST) begin
                    if (enable) begin
                        w_state_nxt = S_ACTIVE;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Position / LFSR / pattern of the pixel that will be presented next cycle.
    // Nothing moves without a fire, which keeps the payload stable under stall.
    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_vcnt_nxt = r_vcnt;
        w_lfsr_nxt = r_lfsr;
        w_sel_nxt  = r_sel;
        if (w_start) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = '0;
            w_lfsr_nxt = LFSR_SEED;
            w_sel_nxt  = pattern_sel;
        end else if (w_fire) begin
            w_lfsr_nxt = {r_lfsr[14:0], w_lfsr_fb};
            if (r_hcnt == H_LAST) begin
                w_hcnt_nxt = '0;
                w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
            end else begin
                w_hcnt_nxt = r_hcnt + 1'b1;
            end
        end
    end

    // Zero-extend / truncate the pattern sources to the pixel width.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_px
            if (gi < HW) begin : g_h
                assign w_h_px[gi] = w_hcnt_nxt[gi];
            end else begin : g_hz
                assign w_h_px[gi] = 1'b0;
            end
            if (gi < VW) begin : g_v
                assign w_v_px[gi] = w_vcnt_nxt[gi];
            end else begin : g_vz
                assign w_v_px[gi] = 1'b0;
            end
            if (gi < 16) begin : g_l
                assign w_l_px[gi] = w_lfsr_nxt[gi];
            end else begin : g_lz
                assign w_l_px[gi] = 1'b0;
            end
        end
        if (HW > 3) begin : g_h3
            assign w_h3 = w_hcnt_nxt[3];
        end else begin : g_h3z
            assign w_h3 = 1'b0;
        end
        if (VW > 3) begin : g_v3
            assign w_v3 = w_vcnt_nxt[3];
        end else begin : g_v3z
            assign w_v3 = 1'b0;
        end
    endgenerate

    // Output logic: next values of the registered stream outputs.
    always_comb begin
        w_pixel      = '0;
        w_tvalid_nxt = (w_state_nxt == S_ACTIVE);
        case (w_sel_nxt)
            2'd0:    w_pixel = w_h_px;
            2'd1:    w_pixel = w_v_px;
            2'd2:    w_pixel = (w_h3 ^ w_v3) ? '1 : '0;
            default: w_pixel = w_l_px;
        endcase
        w_tdata_nxt = w_tvalid_nxt ? w_pixel : '0;
        w_tlast_nxt = w_tvalid_nxt && (w_hcnt_nxt == H_LAST);
        w_tuser_nxt = w_tvalid_nxt && (w_hcnt_nxt == '0) && (w_vcnt_nxt == '0);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_lfsr       <= LFSR_SEED;
            r_sel        <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_hcnt       <= w_hcnt_nxt;
            r_vcnt       <= w_vcnt_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_sel        <= w_sel_nxt;
            r_tdata      <= w_tdata_nxt;
            r_tvalid     <= w_tvalid_nxt;
            r_tlast      <= w_tlast_nxt;
            r_tuser      <= w_tuser_nxt;
            r_frame_done <= w_eof;
            if (w_eof) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Gap counter: runs while sitting in HGAP/VGAP, cleared on any transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if ((r_state == S_HGAP || r_state == S_VGAP) && (w_state_nxt == r_state)) begin
            r_gap <= r_gap + 1'b1;
        end else begin
            r_gap <= '0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb/tb_axis_video_pattern_gen.sv - self-checking bench for axis_video_pattern_gen

module tb_axis_video_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       en_a  = 1'b0, en_b  = 1'b0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic [1:0] sel_a = 2'd0, sel_b = 2'd0;

    logic [7:0]  a_data, b_data;
    logic        a_valid, a_last, a_user, a_done;
    logic        b_valid, b_last, b_user, b_done;
    logic [15:0] a_cnt, b_cnt;

    // A: tiny frame, no line gap, 2-cycle frame gap
    axis_video_pattern_gen #(
        .DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .HGAP_CYCLES(0), .VGAP_CYCLES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel_a),
        .m_axis_tdata(a_data), .m_axis_tvalid(a_valid), .m_axis_tlast(a_last),
        .m_axis_tuser(a_user), .m_axis_tready(rdy_a), .frame_done(a_done), .frame_cnt(a_cnt)
    );

    // B: 16x16 frame, 3-cycle line gap, zero frame gap
    axis_video_pattern_gen #(
        .DATA_WIDTH(8), .FRAME_WIDTH(16), .FRAME_HEIGHT(16), .HGAP_CYCLES(3), .VGAP_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel_b),
        .m_axis_tdata(b_data), .m_axis_tvalid(b_valid), .m_axis_tlast(b_last),
        .m_axis_tuser(b_user), .m_axis_tready(rdy_b), .frame_done(b_done), .frame_cnt(b_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int done_a[$];
    always @(negedge clk) if (a_done === 1'b1) done_a.push_back(cyc);

    logic [9:0] cap_beat[$];
    int         cap_cyc[$];
    int         cap_stall_err;
    bit         cap_timeout;

    // Reference pixel {tuser, tlast, tdata} for beat i of a w x h frame.
    function automatic logic [9:0] exp_beat(int w, int h, int sel, int i);
        int x = i % w;
        int y = i / w;
        logic [7:0]  d;
        logic [15:0] l;
        case (sel)
            0: d = 8'(x);
            1: d = 8'(y);
            2: d = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
            default: begin
                l = 16'hACE1;
                repeat (i) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                d = l[7:0];
            end
        endcase
        if (y >= h) d = 8'hXX;
        return {(x == 0 && y == 0), (x == w - 1), d};
    endfunction

    // Drive tready randomly and record accepted beats, fire cycles and stall violations.
    task automatic capture(input bit b, input int n, input int pct, input bit append);
        int         waited = 0;
        bit         hold = 0;
        bit         r;
        logic       v;
        logic [9:0] pl, held;
        held = '0;
        if (!append) begin
            cap_beat.delete();
            cap_cyc.delete();
        end
        cap_stall_err = 0;
        cap_timeout   = 0;
        n = n + cap_beat.size();
        while (cap_beat.size() < n) begin
            @(negedge clk);
            v  = b ? b_valid : a_valid;
            pl = b ? {b_user, b_last, b_data} : {a_user, a_last, a_data};
            if (hold && (v !== 1'b1 || pl !== held)) cap_stall_err++;
            r = ($urandom_range(99) < pct);
            if (b) rdy_b = r; else rdy_a = r;
            if (v === 1'b1 && r) begin
                cap_beat.push_back(pl);
                cap_cyc.push_back(cyc + 1);
                hold = 0;
            end else begin
                hold = (v === 1'b1);
                held = pl;
            end
            waited++;
            if (waited > n * 8 + 64) begin
                cap_timeout = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    task automatic do_reset();
        en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_a.delete();
    endtask

    task automatic test_reset();
        en_a = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a_data, a_valid, a_last, a_user, a_done, a_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", {a_data, a_valid, a_last, a_user, a_done, a_cnt});
        end
        n_tests++;
        if ({b_data, b_valid, b_last, b_user, b_done, b_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {b_data, b_valid, b_last, b_user, b_done, b_cnt});
        end
        en_a = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid: got %b expected 0", a_valid);
            end
        end
        sel_a = 2'd0;
        en_a  = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_valid, a_user, a_last, a_data} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL start_latency: got %h expected %h", {a_valid, a_user, a_last, a_data},
                     {1'b1, 1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_hramp();
        logic [9:0] e;
        int         d;
        do_reset();
        sel_a = 2'd0;
        en_a  = 1'b1;
        capture(0, 16, 100, 0);
        n_tests++;
        if (cap_timeout || cap_beat.size() != 16) begin
            n_fail++;
            $display("FAIL hramp_count: got %0d expected 16", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, 0, k % 8);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL hramp_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        for (int k = 1; k < cap_cyc.size(); k++) begin
            d = (k == 8) ? 3 : 1;
            n_tests++;
            if (cap_cyc[k] - cap_cyc[k - 1] !== d) begin
                n_fail++;
                $display("FAIL hramp_spacing[%0d]: got %0d expected %0d", k, cap_cyc[k] - cap_cyc[k - 1], d);
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_a.size() != 2 || cap_cyc.size() != 16) begin
            n_fail++;
            $display("FAIL frame_done_pulses: got %0d expected 2", done_a.size());
        end else begin
            for (int f = 0; f < 2; f++) begin
                n_tests++;
                if (done_a[f] != cap_cyc[8 * f + 7]) begin
                    n_fail++;
                    $display("FAIL frame_done_cycle[%0d]: got %0d expected %0d", f, done_a[f], cap_cyc[8 * f + 7]);
                end
            end
        end
        n_tests++;
        if (a_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL hramp_frame_cnt: got %0d expected 2", a_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] e;
        do_reset();
        sel_a = 2'd0;
        en_a  = 1'b1;
        capture(0, 16, 45, 0);
        n_tests++;
        if (cap_timeout || cap_beat.size() != 16) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected 16", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, 0, k % 8);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL bp_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        n_tests++;
        if (cap_stall_err != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d stall violations expected 0", cap_stall_err);
        end
    endtask

    task automatic test_sel_latch();
        logic [9:0] e;
        int         errs;
        do_reset();
        sel_a = 2'd1;
        en_a  = 1'b1;
        capture(0, 3, 60, 0);
        errs = cap_stall_err;
        sel_a = 2'd2;
        capture(0, 13, 60, 1);
        errs += cap_stall_err;
        n_tests++;
        if (cap_timeout || cap_beat.size() != 16) begin
            n_fail++;
            $display("FAIL latch_count: got %0d expected 16", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, (k < 8) ? 1 : 2, k % 8);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL latch_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL latch_hold: got %0d stall violations expected 0", errs);
        end
    endtask

    task automatic test_lfsr();
        logic [9:0] e;
        do_reset();
        sel_a = 2'd3;
        en_a  = 1'b1;
        capture(0, 16, 40, 0);
        n_tests++;
        if (cap_timeout || cap_beat.size() != 16) begin
            n_fail++;
            $display("FAIL lfsr_count: got %0d expected 16", cap_beat.size());
        end
        n_tests++;
        if (cap_beat.size() < 1 || cap_beat[0][7:0] !== 8'hE1) begin
            n_fail++;
            $display("FAIL lfsr_first: got %h expected e1", (cap_beat.size() > 0) ? cap_beat[0][7:0] : 8'hXX);
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, 3, k % 8);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL lfsr_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        n_tests++;
        if (cap_stall_err != 0) begin
            n_fail++;
            $display("FAIL lfsr_hold: got %0d stall violations expected 0", cap_stall_err);
        end
    endtask

    task automatic test_checker();
        logic [9:0] e;
        do_reset();
        sel_b = 2'd2;
        en_b  = 1'b1;
        capture(1, 256, 70, 0);
        en_b = 1'b0;
        n_tests++;
        if (cap_timeout || cap_beat.size() != 256) begin
            n_fail++;
            $display("FAIL chk_count: got %0d expected 256", cap_beat.size());
        end else begin
            n_tests++;
            if (cap_beat[8][7:0] !== 8'hFF) begin
                n_fail++;
                $display("FAIL chk_px_8_0: got %h expected ff", cap_beat[8][7:0]);
            end
            n_tests++;
            if (cap_beat[136][7:0] !== 8'h00) begin
                n_fail++;
                $display("FAIL chk_px_8_8: got %h expected 00", cap_beat[136][7:0]);
            end
            n_tests++;
            if (cap_beat[128][7:0] !== 8'hFF) begin
                n_fail++;
                $display("FAIL chk_px_0_8: got %h expected ff", cap_beat[128][7:0]);
            end
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(16, 16, 2, k);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL chk_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
    endtask

    task automatic test_gaps();
        logic [9:0] e;
        int         d;
        do_reset();
        sel_b = 2'd0;
        en_b  = 1'b1;
        capture(1, 512, 100, 0);
        en_b = 1'b0;
        n_tests++;
        if (cap_timeout || cap_beat.size() != 512) begin
            n_fail++;
            $display("FAIL gap_count: got %0d expected 512", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(16, 16, 0, k % 256);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL gap_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        for (int k = 1; k < cap_cyc.size(); k++) begin
            d = (k % 256 == 0) ? 2 : ((k % 16 == 0) ? 4 : 1);
            n_tests++;
            if (cap_cyc[k] - cap_cyc[k - 1] !== d) begin
                n_fail++;
                $display("FAIL gap_spacing[%0d]: got %0d expected %0d", k, cap_cyc[k] - cap_cyc[k - 1], d);
            end
        end
        @(negedge clk);
        n_tests++;
        if (b_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL gap_frame_cnt: got %0d expected 2", b_cnt);
        end
    endtask

    task automatic test_enable_drop();
        logic [9:0] e;
        int         highs = 0;
        do_reset();
        sel_a = 2'd0;
        en_a  = 1'b1;
        capture(0, 3, 100, 0);
        en_a = 1'b0;
        capture(0, 5, 100, 1);
        n_tests++;
        if (cap_timeout || cap_beat.size() != 8) begin
            n_fail++;
            $display("FAIL drop_count: got %0d expected 8", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, 0, k);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL drop_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        rdy_a = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (a_valid !== 1'b0) highs++;
        end
        rdy_a = 1'b0;
        n_tests++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL drop_idle: got %0d valid cycles expected 0", highs);
        end
        n_tests++;
        if (a_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_frame_cnt: got %0d expected 1", a_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] e;
        do_reset();
        sel_a = 2'd0;
        en_a  = 1'b1;
        capture(0, 10, 100, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_data, a_valid, a_last, a_user, a_done, a_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", {a_data, a_valid, a_last, a_user, a_done, a_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_valid, a_user, a_data, a_cnt} !== {1'b1, 1'b1, 8'h00, 16'h0000}) begin
            n_fail++;
            $display("FAIL midreset_restart: got %h expected %h", {a_valid, a_user, a_data, a_cnt},
                     {1'b1, 1'b1, 8'h00, 16'h0000});
        end
        capture(0, 8, 100, 0);
        n_tests++;
        if (cap_timeout || cap_beat.size() != 8) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d expected 8", cap_beat.size());
        end
        for (int k = 0; k < cap_beat.size(); k++) begin
            e = exp_beat(4, 2, 0, k);
            n_tests++;
            if (cap_beat[k] !== e) begin
                n_fail++;
                $display("FAIL midreset_beat[%0d]: got %h expected %h", k, cap_beat[k], e);
            end
        end
        @(negedge clk);
        n_tests++;
        if (a_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_frame_cnt: got %0d expected 1", a_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_hramp();
        test_backpressure();
        test_sel_latch();
        test_lfsr();
        test_checker();
        test_gaps();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
